// File: rtl/metronome_tempo.sv
// metronome_tempo: BPM register, tap-tempo recorder with restoring divider, phase-accumulator beat clock; no backpressure.
// Tap result lands 18 cycles after the second tap. Define METRONOME_ACCENT_EN to add the first-beat-of-bar accent.
module metronome_tempo #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000,
  parameter int MIN_BPM = 30,
  parameter int MAX_BPM = 99,
  parameter int DEF_BPM = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tapIn,
  input  logic       recIn,
  input  logic       upIn,
  input  logic       downIn,
  output logic [6:0] bpmOut,
  output logic [3:0] tensOut,
  output logic [3:0] onesOut,
  output logic       bclk,
  output logic       beatPulse,
  output logic       isRecord,
  output logic       accent
);
  localparam logic [1:0]    S_PLAY   = 2'd0;
  localparam logic [1:0]    S_ARMED  = 2'd1;
  localparam logic [1:0]    S_TIMING = 2'd2;
  localparam logic [1:0]    S_DIVIDE = 2'd3;
  localparam logic [33:0]   LIM      = 34'(CLK_HZ) * 34'd60;
  localparam logic [33:0]   HALF     = LIM >> 1;
  localparam int            TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [10:0]   TIMEOUT  = 11'(60000 / MIN_BPM);
  localparam logic [6:0]    BPM_MIN  = 7'(MIN_BPM);
  localparam logic [6:0]    BPM_MAX  = 7'(MAX_BPM);
  localparam logic [6:0]    BPM_DEF  = 7'(DEF_BPM);
  localparam logic [15:0]   DIVIDEND = 16'd60000;

  logic [1:0]    r_state, w_state_next;
  logic [6:0]    r_bpm, r_clamp, w_clamp;
  logic [3:0]    r_tens, r_ones;
  logic [33:0]   r_acc, w_sum, w_acc_next;
  logic          r_bclk, r_beat, r_rec, w_wrap, w_tick, w_ge, w_load;
  logic [PW-1:0] r_pre;
  logic [10:0]   r_ms, w_ms_next, r_div, r_rem;
  logic [11:0]   w_trial;
  logic [15:0]   r_q;
  logic [4:0]    r_cnt;

  assign w_sum      = r_acc + {27'd0, r_bpm};
  assign w_wrap     = (w_sum >= LIM);
  assign w_acc_next = w_wrap ? (w_sum - LIM) : w_sum;
  assign w_tick     = (r_pre == PRE_LAST);
  assign w_ms_next  = w_tick ? (r_ms + 11'd1) : r_ms;
  assign w_trial    = {r_rem, r_q[15]};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  assign w_load     = (r_state == S_DIVIDE) && (r_cnt == 5'd17);
  assign w_clamp    = (r_q < 16'(MIN_BPM)) ? BPM_MIN :
                      (r_q > 16'(MAX_BPM)) ? BPM_MAX : r_q[6:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PLAY:   if (recIn) w_state_next = S_ARMED;
      S_ARMED:  if (recIn) w_state_next = S_PLAY;
                else if (tapIn) w_state_next = S_TIMING;
      S_TIMING: if (recIn) w_state_next = S_PLAY;
                else if (tapIn) w_state_next = S_DIVIDE;
                else if (w_ms_next == TIMEOUT) w_state_next = S_PLAY;
      default:  if (r_cnt == 5'd17) w_state_next = S_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_PLAY;
      r_rec   <= 1'b0;
      r_bpm   <= BPM_DEF;
      r_clamp <= BPM_DEF;
      r_pre   <= '0;
      r_ms    <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_rec   <= (w_state_next != S_PLAY);
      case (r_state)
        S_PLAY: begin
          if (upIn && !downIn && (r_bpm < BPM_MAX)) r_bpm <= r_bpm + 7'd1;
          else if (downIn && !upIn && (r_bpm > BPM_MIN)) r_bpm <= r_bpm - 7'd1;
        end
        S_ARMED: begin
          r_pre <= '0;
          r_ms  <= '0;
        end
        S_TIMING: begin
          r_pre <= w_tick ? '0 : (r_pre + PW'(1));
          r_ms  <= w_ms_next;
          if (w_state_next == S_DIVIDE) begin
            r_div <= w_ms_next;
            r_rem <= '0;
            r_q   <= DIVIDEND;
            r_cnt <= '0;
          end
        end
        default: begin
          // cycles 0-15 shift out one quotient bit each, 16 clamps, 17 commits
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt < 5'd16) begin
            r_rem <= w_ge ? 11'(w_trial - {1'b0, r_div}) : w_trial[10:0];
            r_q   <= {r_q[14:0], w_ge};
          end else if (r_cnt == 5'd16) begin
            r_clamp <= w_clamp;
          end else begin
            r_bpm <= r_clamp;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_bclk <= 1'b1;
      r_beat <= 1'b0;
      r_tens <= 4'(DEF_BPM / 10);
      r_ones <= 4'(DEF_BPM % 10);
    end else if (w_load) begin
      // tap result restarts the beat phase so the new tempo begins on a downbeat
      r_acc  <= '0;
      r_bclk <= 1'b1;
      r_beat <= 1'b0;
      r_tens <= 4'(r_clamp / 7'd10);
      r_ones <= 4'(r_clamp % 7'd10);
    end else begin
      r_acc  <= w_acc_next;
      r_bclk <= (w_acc_next < HALF);
      r_beat <= w_wrap;
      r_tens <= 4'(r_bpm / 7'd10);
      r_ones <= 4'(r_bpm % 7'd10);
    end
  end

`ifdef METRONOME_ACCENT_EN
  logic [1:0] r_bar;
  logic       r_accent;

  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_bar    <= '0;
      r_accent <= 1'b0;
    end else begin
      r_accent <= w_wrap && (r_bar == 2'd0);
      if (w_wrap) r_bar <= r_bar + 2'd1;
    end
  end

  assign accent = r_accent;
`else
  assign accent = 1'b0;
`endif

  assign bpmOut    = r_bpm;
  assign tensOut   = r_tens;
  assign onesOut   = r_ones;
  assign bclk      = r_bclk;
  assign beatPulse = r_beat;
  assign isRecord  = r_rec;
endmodule

// File: tb/tb_metronome_tempo.sv
// Bench for metronome_tempo: random up/down presses and tap intervals checked against an arithmetic tempo model.
module tb_metronome_tempo;
  localparam int CLK_HZ     = 6000;
  localparam int TICK_HZ    = 1000;
  localparam int LIM        = CLK_HZ * 60;
  localparam int CYC_PER_MS = CLK_HZ / TICK_HZ;
`ifdef METRONOME_ACCENT_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tapIn, recIn, upIn, downIn;
  logic [6:0] bpmOut;
  logic [3:0] tensOut, onesOut;
  logic       bclk, beatPulse, isRecord, accent;

  int n_chk  = 0;
  int n_fail = 0;
  int m_bpm;

  metronome_tempo #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MIN_BPM(30), .MAX_BPM(99), .DEF_BPM(60)) dut (
    .clk(clk), .rst(rst), .tapIn(tapIn), .recIn(recIn), .upIn(upIn), .downIn(downIn),
    .bpmOut(bpmOut), .tensOut(tensOut), .onesOut(onesOut), .bclk(bclk),
    .beatPulse(beatPulse), .isRecord(isRecord), .accent(accent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tap_bpm(input int gap);
    int ms, q;
    ms = gap / CYC_PER_MS;
    q  = (ms == 0) ? 65535 : 60000 / ms;
    if (q > 99) q = 99;
    if (q < 30) q = 30;
    return q;
  endfunction

  // Beats run from a zero phase: beat k starts k*period cycles later, clock high for the first half.
  task automatic run_beats(input int n, input int bpm);
    int period, p;
    bit exp_pulse;
    period = LIM / bpm;
    for (int i = 1; i <= n; i++) begin
      tick();
      p = i % period;
      exp_pulse = (p == 0);
      check("beatPulse", beatPulse, exp_pulse);
      check("bclk", bclk, p < period / 2);
      check("accent", accent, ACC_EN && exp_pulse && (((i / period) - 1) % 4 == 0));
    end
  endtask

  task automatic press(input bit u, input bit d);
    upIn = u; downIn = d;
    tick();
    upIn = 1'b0; downIn = 1'b0;
    if (u && !d && m_bpm < 99) m_bpm++;
    else if (d && !u && m_bpm > 30) m_bpm--;
    check("bpm_updown", bpmOut, m_bpm);
    tick();
    check("tens_updown", tensOut, m_bpm / 10);
    check("ones_updown", onesOut, m_bpm % 10);
  endtask

  // mode 0: plain; mode 1: stray inputs during divide; mode 2: reset during divide
  task automatic tap_run(input int gap, input int mode);
    int exp_bpm;
    exp_bpm = tap_bpm(gap);
    recIn = 1'b1; tick(); recIn = 1'b0;
    check("rec_armed", isRecord, 1'b1);
    upIn = 1'b1; tick(); upIn = 1'b0;
    check("up_ignored_armed", bpmOut, m_bpm);
    tapIn = 1'b1; tick(); tapIn = 1'b0;
    for (int i = 1; i < gap; i++) begin
      tick();
      check("rec_timing", isRecord, 1'b1);
    end
    tapIn = 1'b1; tick(); tapIn = 1'b0;
    if (mode == 2) begin
      for (int i = 1; i <= 7; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      m_bpm = 60;
      check("rst_div_bpm", bpmOut, 60);
      check("rst_div_rec", isRecord, 1'b0);
      check("rst_div_tens", tensOut, 6);
      check("rst_div_ones", onesOut, 0);
      check("rst_div_bclk", bclk, 1'b1);
      for (int i = 0; i < 30; i++) tick();
      check("rst_div_late_bpm", bpmOut, 60);
      check("rst_div_late_rec", isRecord, 1'b0);
      press(1'b1, 1'b0);
    end else begin
      for (int i = 1; i <= 17; i++) begin
        if (mode == 1 && i == 5) begin
          tapIn = 1'b1; recIn = 1'b1; upIn = 1'b1;
        end
        tick();
        tapIn = 1'b0; recIn = 1'b0; upIn = 1'b0;
      end
      check("bpm_before_T18", bpmOut, m_bpm);
      check("rec_before_T18", isRecord, 1'b1);
      tick();
      m_bpm = exp_bpm;
      check("tap_bpm", bpmOut, exp_bpm);
      check("tap_tens", tensOut, exp_bpm / 10);
      check("tap_ones", onesOut, exp_bpm % 10);
      check("tap_rec_off", isRecord, 1'b0);
      check("tap_bclk", bclk, 1'b1);
      check("tap_nopulse", beatPulse, 1'b0);
      if (mode == 1) begin
        for (int i = 0; i < 5; i++) tick();
        check("stray_rec", isRecord, 1'b0);
        check("stray_bpm", bpmOut, exp_bpm);
      end
    end
  endtask

  initial begin
    int op, gap;
    rst = 1'b1; tapIn = 1'b0; recIn = 1'b0; upIn = 1'b0; downIn = 1'b0;
    m_bpm = 60;
    for (int i = 0; i < 3; i++) tick();
    check("rst_bpm", bpmOut, 60);
    check("rst_tens", tensOut, 6);
    check("rst_ones", onesOut, 0);
    check("rst_bclk", bclk, 1'b1);
    check("rst_pulse", beatPulse, 1'b0);
    check("rst_rec", isRecord, 1'b0);
    check("rst_accent", accent, 1'b0);
    rst = 1'b0;
    run_beats(30000, 60);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      press(op[0], op[1]);
    end
    for (int i = 0; i < 75; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("sat_max", bpmOut, 99);
    for (int i = 0; i < 75; i++) press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("sat_min", bpmOut, 30);
    press(1'b1, 1'b1);

    tap_run(4500, 0);
    check("tap_750ms", bpmOut, 80);
    run_beats(9000, 80);
    tap_run(3000, 0);
    check("tap_clamp_max", bpmOut, 99);
    for (int k = 0; k < 2; k++) begin
      gap = $urandom_range(600, 6000);
      tap_run(gap, 0);
    end

    recIn = 1'b1; tick(); recIn = 1'b0;
    tapIn = 1'b1; tick(); tapIn = 1'b0;
    for (int i = 1; i < 12000; i++) tick();
    check("timeout_rec_before", isRecord, 1'b1);
    tick();
    check("timeout_rec_off", isRecord, 1'b0);
    check("timeout_bpm", bpmOut, m_bpm);
    press(1'b0, 1'b1);

    tap_run(4200, 1);
    check("stray_result", bpmOut, 85);
    tap_run(1200, 2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
